// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction fetch stage. Holds the fetch PC, reads the
//            instruction memory combinationally, and buffers fetched words
//            in a 2-entry FIFO of {instr, pc} that feeds the decode stage.
//            A taken branch/jump (redirect) flushes the FIFO and reloads
//            the fetch PC.
//
// Ports    : clk          - sole clock, rising edge
//            rst_n        - asynchronous active-low reset
//            imem_addr    - fetch address to instruction memory
//            imem_rd      - instruction word returned for imem_addr
//            redirect     - branch/jump taken, replaces the fetch PC
//            redirect_pc  - redirect target address
//            id_ready     - decode accepts the head entry this cycle
//            id_valid     - head entry present
//            id_instr     - head instruction word
//            id_pc        - head instruction address
//            id_pc_plus4  - head instruction address + 4
//            fetch_fault  - misaligned redirect target detected
//
// Config   : FETCH_MISALIGN_TRAP_EN - when defined, a misaligned redirect
//            target raises fetch_fault and halts fetching until an aligned
//            redirect arrives. When undefined, the target is force-aligned
//            and fetch_fault is tied low.
//
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_fault
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] r_fetch_pc;
    logic [1:0]  r_count;       // 0..2 entries
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [31:0] r_instr [2];
    logic [31:0] r_pc    [2];

    logic        w_pop;
    logic        w_push;
    logic        w_halted;
    logic [31:0] w_redirect_target;

    // Low two bits are cleared in both build variants; in the trapping
    // variant they only matter for fault detection because fetch is halted
    // until a good target arrives.
    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
    // The fault flag and the halted state are set and cleared by exactly the
    // same events, so one register serves as both.
    logic r_halted;
    logic w_misaligned;

    assign w_misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else if (redirect) begin
            r_halted <= w_misaligned;
        end
    end

    assign w_halted    = r_halted;
    assign fetch_fault = r_halted;
`else
    assign w_halted    = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign id_valid = (r_count != 2'd0);
    assign w_pop    = id_valid & id_ready;
    // A full queue can still accept a new word when the head leaves in the
    // same cycle, which keeps one instruction per cycle flowing.
    assign w_push   = ~redirect & ~w_halted & ((r_count < 2'd2) | w_pop);

    assign imem_addr = r_fetch_pc;

    // ------------------------------------------------------------------
    // Fetch PC, pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
        end else if (redirect) begin
            // Flush: any pop in this cycle is discarded along with the rest.
            r_fetch_pc <= w_redirect_target;
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;  // wraps silently
                r_wr_ptr   <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage (no reset needed: contents are qualified by r_count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wr_ptr] <= imem_rd;
            r_pc[r_wr_ptr]    <= r_fetch_pc;
        end
    end

    assign id_instr    = r_instr[r_rd_ptr];
    assign id_pc       = r_pc[r_rd_ptr];
    // Derived from the stored PC so it stays tied to the head entry even
    // after the fetch PC has moved on or been redirected.
    assign id_pc_plus4 = r_pc[r_rd_ptr] + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue. Directed scenarios plus a
//            randomized run compared against a queue-based reference model.
//            Instruction memory returns word n at address 4n.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    fetch_queue #(
        .RESET_PC (c_reset_pc)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .fetch_fault (fetch_fault)
    );

    assign imem_rd = {2'b00, imem_addr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a queue of {instr, pc}, a fetch PC and a halt flag.
    // ------------------------------------------------------------------
    logic [63:0] m_q[$];
    logic [31:0] m_fetch;
    bit          m_halted;
    bit          m_fault;

    task automatic model_reset();
        m_q.delete();
        m_fetch  = c_reset_pc;
        m_halted = 1'b0;
        m_fault  = 1'b0;
    endtask

    // Drive one cycle of inputs, let one rising edge pass, update the model
    // and leave time at edge + 1.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
        bit pop;
        bit push;
        id_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        pop  = (m_q.size() != 0) && rdy;
        push = !redir && !m_halted && ((m_q.size() < 2) || pop);
        @(posedge clk);
        if (redir) begin
            m_q.delete();
            m_fetch = {rpc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
            m_halted = (rpc[1:0] != 2'b00);
            m_fault  = m_halted;
`endif
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({m_fetch >> 2, m_fetch});
                m_fetch = m_fetch + 32'd4;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;
        model_reset();
        #3;
        n_checks++;
        if (id_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_valid: got %0b expected 0", id_valid);
        end
        n_checks++;
        if (fetch_fault !== 1'b0) begin
            n_errors++; $display("FAIL reset_fault: got %0b expected 0", fetch_fault);
        end
        n_checks++;
        if (imem_addr !== c_reset_pc) begin
            n_errors++; $display("FAIL reset_addr: got %08h expected %08h", imem_addr, c_reset_pc);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (id_valid !== 1'b0 || imem_addr !== c_reset_pc) begin
            n_errors++; $display("FAIL reset_hold: got valid=%0b addr=%08h expected valid=0 addr=%08h",
                                 id_valid, imem_addr, c_reset_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Streaming with decode always ready: one entry per cycle from cycle 1.
    task automatic test_stream();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 32'h0);
            n_checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(4 * i) || id_instr !== 32'(i) ||
                id_pc_plus4 !== 32'(4 * i + 4)) begin
                n_errors++;
                $display("FAIL stream_%0d: got valid=%0b pc=%08h instr=%08h pc4=%08h expected valid=1 pc=%08h instr=%08h pc4=%08h",
                         i, id_valid, id_pc, id_instr, id_pc_plus4, 4 * i, i, 4 * i + 4);
            end
        end
    endtask

    // Decode stalls for 5 cycles: queue fills to two and fetch holds.
    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
            n_checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
                n_errors++; $display("FAIL stall_head_%0d: got valid=%0b pc=%08h expected valid=1 pc=00000000",
                                     i, id_valid, id_pc);
            end
        end
        n_checks++;
        if (imem_addr !== 32'h8) begin
            n_errors++; $display("FAIL stall_addr: got %08h expected 00000008", imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(4 * i) || id_instr !== 32'(i)) begin
                n_errors++; $display("FAIL drain_%0d: got valid=%0b pc=%08h instr=%08h expected pc=%08h instr=%08h",
                                     i, id_valid, id_pc, id_instr, 4 * i, i);
            end
            step(1'b1, 1'b0, 32'h0);
        end
    endtask

    // Redirect while full and decode ready: pop discarded, queue flushed.
    task automatic test_redirect();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h100);
        n_checks++;
        if (id_valid !== 1'b0 || imem_addr !== 32'h100) begin
            n_errors++; $display("FAIL redir_flush: got valid=%0b addr=%08h expected valid=0 addr=00000100",
                                 id_valid, imem_addr);
        end
        step(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_pc_plus4 !== 32'h104 || id_instr !== 32'h40) begin
            n_errors++; $display("FAIL redir_target: got valid=%0b pc=%08h pc4=%08h instr=%08h expected 1 00000100 00000104 00000040",
                                 id_valid, id_pc, id_pc_plus4, id_instr);
        end
    endtask

    // PC increment wraps from the top of the address space to zero.
    task automatic test_wrap();
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        n_checks++;
        if (id_valid !== 1'b0) begin
            n_errors++; $display("FAIL wrap_flush: got valid=%0b expected 0", id_valid);
        end
        step(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0 || id_instr !== 32'h3FFF_FFFF) begin
            n_errors++; $display("FAIL wrap_top: got pc=%08h pc4=%08h instr=%08h expected fffffffc 00000000 3fffffff",
                                 id_pc, id_pc_plus4, id_instr);
        end
        step(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) begin
            n_errors++; $display("FAIL wrap_zero: got valid=%0b pc=%08h pc4=%08h expected 1 00000000 00000004",
                                 id_valid, id_pc, id_pc_plus4);
        end
    endtask

    // Misaligned redirect target.
    task automatic test_misalign();
        step(1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (fetch_fault !== 1'b1 || id_valid !== 1'b0) begin
                n_errors++; $display("FAIL trap_halt_%0d: got fault=%0b valid=%0b expected fault=1 valid=0",
                                     i, fetch_fault, id_valid);
            end
            step(1'b1, 1'b0, 32'h0);
        end
        step(1'b1, 1'b1, 32'h200);
        n_checks++;
        if (fetch_fault !== 1'b0 || id_valid !== 1'b0) begin
            n_errors++; $display("FAIL trap_clear: got fault=%0b valid=%0b expected fault=0 valid=0",
                                 fetch_fault, id_valid);
        end
        step(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h200) begin
            n_errors++; $display("FAIL trap_resume: got valid=%0b pc=%08h expected 1 00000200", id_valid, id_pc);
        end
`else
        n_checks++;
        if (fetch_fault !== 1'b0 || imem_addr !== 32'h100) begin
            n_errors++; $display("FAIL align_redir: got fault=%0b addr=%08h expected 0 00000100",
                                 fetch_fault, imem_addr);
        end
        step(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100 || fetch_fault !== 1'b0) begin
            n_errors++; $display("FAIL align_fetch: got valid=%0b pc=%08h fault=%0b expected 1 00000100 0",
                                 id_valid, id_pc, fetch_fault);
        end
`endif
    endtask

    // Reset asserted between edges with a full queue.
    task automatic test_async_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (id_valid !== 1'b1) begin
            n_errors++; $display("FAIL areset_pre: got valid=%0b expected 1", id_valid);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (id_valid !== 1'b0 || imem_addr !== c_reset_pc || fetch_fault !== 1'b0) begin
            n_errors++; $display("FAIL areset_now: got valid=%0b addr=%08h fault=%0b expected 0 %08h 0",
                                 id_valid, imem_addr, fetch_fault, c_reset_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== c_reset_pc) begin
            n_errors++; $display("FAIL areset_first: got valid=%0b pc=%08h expected 1 %08h",
                                 id_valid, id_pc, c_reset_pc);
        end
    endtask

    // Randomized traffic against the reference model.
    task automatic test_random();
        logic [31:0] rpc;
        bit          rdy;
        bit          redir;
        for (int i = 0; i < 400; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = $urandom & 32'hFFFF_FFFC;
                1:       rpc = $urandom;
                2:       rpc = 32'hFFFF_FFF8;
                default: rpc = 32'h0000_1000;
            endcase
            step(rdy, redir, rpc);
            n_checks++;
            if (id_valid !== (m_q.size() != 0) || fetch_fault !== m_fault) begin
                n_errors++; $display("FAIL rand_ctl_%0d: got valid=%0b fault=%0b expected valid=%0b fault=%0b",
                                     i, id_valid, fetch_fault, m_q.size() != 0, m_fault);
            end
            if (!m_halted) begin
                n_checks++;
                if (imem_addr !== m_fetch) begin
                    n_errors++; $display("FAIL rand_addr_%0d: got %08h expected %08h", i, imem_addr, m_fetch);
                end
            end
            if (m_q.size() != 0) begin
                n_checks++;
                if (id_pc !== m_q[0][31:0] || id_instr !== m_q[0][63:32] ||
                    id_pc_plus4 !== m_q[0][31:0] + 32'd4) begin
                    n_errors++; $display("FAIL rand_head_%0d: got pc=%08h instr=%08h pc4=%08h expected pc=%08h instr=%08h pc4=%08h",
                                         i, id_pc, id_instr, id_pc_plus4,
                                         m_q[0][31:0], m_q[0][63:32], m_q[0][31:0] + 32'd4);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_misalign();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
